// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: PC, single-outstanding imem requests, inst handshake
// Optional: define IFU_MISALIGN_CHECK_EN to trap misaligned redirect targets.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halt,
    output logic        fetch_err
);

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        drop;
    logic [31:0] redir_target;
    logic        redir_bad;

`ifdef IFU_MISALIGN_CHECK_EN
    assign redir_target = redirect_pc;
    assign redir_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redir_target        = {redirect_pc[31:2], 2'b00};
    assign redir_bad           = 1'b0;
`endif

    // Gated by rst so the async-reset REQ state does not present a request mid-reset.
    assign imem_req_valid = (state == S_REQ) && !rst;
    assign imem_req_addr  = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            inst       <= 32'h0;
            inst_pc    <= 32'h0;
            inst_valid <= 1'b0;
            halt       <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redir_bad) begin
                        fetch_err <= 1'b1;
                        state     <= S_HALT;
                    end else if (imem_req_ready) begin
                        state <= S_WAIT;
                        if (redirect_valid) begin
                            drop <= 1'b1;
                            pc   <= redir_target;
                        end
                    end else if (redirect_valid) begin
                        pc <= redir_target;
                    end
                end
                S_WAIT: begin
                    if (redir_bad) begin
                        fetch_err <= 1'b1;
                        state     <= S_HALT;
                    end else if (imem_resp_valid) begin
                        if (drop || redirect_valid) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                            if (redirect_valid) begin
                                pc <= redir_target;
                            end
                        end else if (imem_resp_err) begin
                            fetch_err <= 1'b1;
                            state     <= S_HALT;
                        end else begin
                            inst       <= imem_resp_data;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            pc         <= pc + 32'd4;
                            state      <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                        pc   <= redir_target;
                    end
                end
                S_HOLD: begin
                    // A consumed ebreak halts even if a redirect arrives in the same cycle.
                    if (inst_ready && (inst == EBREAK)) begin
                        inst_valid <= 1'b0;
                        halt       <= 1'b1;
                        state      <= S_HALT;
                    end else if (redir_bad) begin
                        inst_valid <= 1'b0;
                        fetch_err  <= 1'b1;
                        state      <= S_HALT;
                    end else if (redirect_valid) begin
                        inst_valid <= 1'b0;
                        pc         <= redir_target;
                        state      <= S_REQ;
                    end else if (inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed self-checking bench for ifu_fetch
module tb_ifu_fetch;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MASK   = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = 32'h0;
    logic        imem_resp_err   = 1'b0;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fetch_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] err_addr    = 32'hFFFF_FFFF;
    logic [31:0] ebreak_addr = 32'hFFFF_FFFF;
    logic        acc_q;
    logic [31:0] acc_addr;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .imem_resp_err  (imem_resp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == ebreak_addr) ? EBREAK : (a ^ MASK);
    endfunction

    // Memory answers every accepted request exactly one cycle later.
    always @(posedge clk) begin
        acc_q    = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        #1;
        imem_resp_valid = acc_q;
        imem_resp_data  = acc_q ? mem_word(acc_addr) : 32'h0;
        imem_resp_err   = acc_q && (acc_addr == err_addr);
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        expect_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        expect_eq("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
        expect_eq("rst_halt", {31'b0, halt}, 32'd0);
        expect_eq("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        rst = 1'b0;
        #1;
        expect_eq("rst_addr", imem_req_addr, 32'h8000_0000);
        expect_eq("rst_req_up", {31'b0, imem_req_valid}, 32'd1);
    endtask

    // Starts in REQ with memory ready and inst_ready high; ends back in REQ.
    task automatic fetch_one(input logic [31:0] a);
        expect_eq("f_req_valid", {31'b0, imem_req_valid}, 32'd1);
        expect_eq("f_req_addr", imem_req_addr, a);
        tick();
        expect_eq("f_wait_req", {31'b0, imem_req_valid}, 32'd0);
        expect_eq("f_wait_iv", {31'b0, inst_valid}, 32'd0);
        tick();
        expect_eq("f_iv", {31'b0, inst_valid}, 32'd1);
        expect_eq("f_inst_pc", inst_pc, a);
        expect_eq("f_inst", inst, mem_word(a));
        tick();
        expect_eq("f_iv_clr", {31'b0, inst_valid}, 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        expect_eq("async_rst_inst_pc", inst_pc, 32'h0);
        expect_eq("async_rst_inst", inst, 32'h0);
        tick();
        do_reset();

        // Back-to-back fetches, 3 cycles each.
        fetch_one(32'h8000_0000);
        fetch_one(32'h8000_0004);
        fetch_one(32'h8000_0008);

        // Downstream stall for 5 cycles.
        inst_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            expect_eq("stall_iv", {31'b0, inst_valid}, 32'd1);
            expect_eq("stall_pc", inst_pc, 32'h8000_000C);
            expect_eq("stall_inst", inst, 32'h8000_000C ^ MASK);
            expect_eq("stall_noreq", {31'b0, imem_req_valid}, 32'd0);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        expect_eq("stall_done_iv", {31'b0, inst_valid}, 32'd0);
        expect_eq("stall_next_addr", imem_req_addr, 32'h8000_0010);

        // Redirect while WAIT; concurrent response is discarded.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        expect_eq("rw_iv", {31'b0, inst_valid}, 32'd0);
        fetch_one(32'h8000_0100);

        // Redirect in REQ while accepted: old request issued, its response dropped.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        expect_eq("rr_wait", {31'b0, imem_req_valid}, 32'd0);
        tick();
        expect_eq("rr_drop_iv", {31'b0, inst_valid}, 32'd0);
        fetch_one(32'h8000_0200);

        // Redirect in HOLD without inst_ready.
        inst_ready = 1'b0;
        tick();
        tick();
        expect_eq("rh_iv", {31'b0, inst_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0500;
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        expect_eq("rh_iv_clr", {31'b0, inst_valid}, 32'd0);
        fetch_one(32'h8000_0500);

        // Misaligned redirect target.
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0302;
        tick();
        redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
        expect_eq("mis_err", {31'b0, fetch_err}, 32'd1);
        expect_eq("mis_noreq", {31'b0, imem_req_valid}, 32'd0);
`else
        expect_eq("mis_err", {31'b0, fetch_err}, 32'd0);
        expect_eq("mis_addr", imem_req_addr, 32'h8000_0300);
`endif
        imem_req_ready = 1'b1;

        // Bus error halts fetch until reset.
        do_reset();
        err_addr = 32'h8000_0000;
        tick();
        tick();
        expect_eq("err_flag", {31'b0, fetch_err}, 32'd1);
        expect_eq("err_iv", {31'b0, inst_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            expect_eq("err_noreq", {31'b0, imem_req_valid}, 32'd0);
            tick();
        end
        err_addr = 32'hFFFF_FFFF;
        rst = 1'b1;
        #1;
        expect_eq("err_rst_clr", {31'b0, fetch_err}, 32'd0);
        do_reset();

        // ebreak consumed with a simultaneous redirect: halt wins.
        ebreak_addr = 32'h8000_0004;
        fetch_one(32'h8000_0000);
        tick();
        tick();
        expect_eq("eb_inst", inst, EBREAK);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0400;
        tick();
        expect_eq("eb_halt", {31'b0, halt}, 32'd1);
        expect_eq("eb_iv", {31'b0, inst_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            expect_eq("eb_noreq", {31'b0, imem_req_valid}, 32'd0);
            tick();
        end
        redirect_valid = 1'b0;
        ebreak_addr    = 32'hFFFF_FFFF;

        // PC wraps from 0xFFFFFFFC to 0.
        do_reset();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        fetch_one(32'hFFFF_FFFC);
        expect_eq("wrap_addr", imem_req_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
